// File: rtl/pc_predict_pkg.sv
// rtl/pc_predict_pkg.sv - branch condition codes, counter states and condition evaluation
package pc_predict_pkg;

  localparam logic [2:0] COND_NE   = 3'b000;
  localparam logic [2:0] COND_EQ   = 3'b001;
  localparam logic [2:0] COND_GT   = 3'b010;
  localparam logic [2:0] COND_LT   = 3'b011;
  localparam logic [2:0] COND_GE   = 3'b100;
  localparam logic [2:0] COND_LE   = 3'b101;
  localparam logic [2:0] COND_OVFL = 3'b110;
  localparam logic [2:0] COND_AL   = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // flags are packed {V,N,Z}
  function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] flags);
    logic v, n, z;
    v = flags[2];
    n = flags[1];
    z = flags[0];
    case (cond)
      COND_NE:   return ~z;
      COND_EQ:   return z;
      COND_GT:   return ~n & ~z;
      COND_LT:   return n;
      COND_GE:   return ~n | z;
      COND_LE:   return n | z;
      COND_OVFL: return v;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pc_predict_unit_btb_table.sv
// rtl/pc_predict_unit_btb_table.sv - direct-mapped BTB storage with async lookup and sync update
module btb_table
  import pc_predict_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = ADDR_W - IDX_W - 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [ADDR_W-1:0] rd_target_o,
  output logic [1:0]        rd_ctr_o,
  input  logic              upd_en_i,
  input  logic [IDX_W-1:0]  upd_idx_i,
  input  logic [TAG_W-1:0]  upd_tag_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i
);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic       upd_hit;
  logic [1:0] cur_ctr;
  logic [1:0] ctr_d;

  // Lookup sees pre-update contents; a same-cycle write lands on the edge.
  assign rd_valid_o  = valid_q[rd_idx_i];
  assign rd_tag_o    = tag_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];
  assign rd_ctr_o    = ctr_q[rd_idx_i];

  assign upd_hit = valid_q[upd_idx_i] && (tag_q[upd_idx_i] == upd_tag_i);
  assign cur_ctr = ctr_q[upd_idx_i];

  always_comb begin
    ctr_d = cur_ctr;
    if (upd_taken_i) begin
      if (cur_ctr != ST) ctr_d = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != SNT) ctr_d = cur_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (upd_en_i) begin
      if (upd_hit) begin
        ctr_q[upd_idx_i] <= ctr_d;
        if (upd_taken_i) target_q[upd_idx_i] <= upd_target_i;
      end else if (upd_taken_i) begin
        valid_q[upd_idx_i]  <= 1'b1;
        tag_q[upd_idx_i]    <= upd_tag_i;
        target_q[upd_idx_i] <= upd_target_i;
        ctr_q[upd_idx_i]    <= WT;
      end
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// rtl/pc_predict_unit.sv - fetch PC register with BTB prediction, branch resolution and statistics
module pc_predict_unit
  import pc_predict_pkg::*;
#(
  parameter int               ADDR_W      = 16,
  parameter int               BTB_ENTRIES = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int               CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] fetch_pc_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              ex_valid_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic [2:0]        ex_cond_i,
  input  logic [2:0]        ex_flags_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  input  logic              ex_pred_taken_i,
  input  logic [ADDR_W-1:0] ex_pred_target_i,
  output logic              ex_taken_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]  branch_count_o,
  output logic [CNT_W-1:0]  mispredict_count_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [ADDR_W-1:0] rd_target;
  logic [1:0]        rd_ctr;

  btb_table #(
    .ENTRIES (BTB_ENTRIES),
    .ADDR_W  (ADDR_W)
  ) u_btb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rd_idx_i     (fetch_pc_q[IDX_W:1]),
    .rd_valid_o   (rd_valid),
    .rd_tag_o     (rd_tag),
    .rd_target_o  (rd_target),
    .rd_ctr_o     (rd_ctr),
    .upd_en_i     (ex_valid_i),
    .upd_idx_i    (ex_pc_i[IDX_W:1]),
    .upd_tag_i    (ex_pc_i[ADDR_W-1:IDX_W+1]),
    .upd_taken_i  (ex_taken_o),
    .upd_target_i (ex_target_i)
  );

  assign fetch_pc_o    = fetch_pc_q;
  assign pred_taken_o  = rd_valid & (rd_tag == fetch_pc_q[ADDR_W-1:IDX_W+1]) & rd_ctr[1];
  assign pred_target_o = pred_taken_o ? rd_target : fetch_pc_q + ADDR_W'(2);

  assign ex_taken_o    = ex_valid_i & cond_met(ex_cond_i, ex_flags_i);
  assign flush_o       = ex_valid_i & ((ex_taken_o != ex_pred_taken_i) |
                                       (ex_taken_o & (ex_target_i != ex_pred_target_i)));
  assign redirect_pc_o = ex_taken_o ? ex_target_i : ex_pc_i + ADDR_W'(2);

  // A redirect must win over halt so a wrong-path HLT cannot freeze fetch.
  always_comb begin
    fetch_pc_d = pred_target_o;
    if (flush_o)                fetch_pc_d = redirect_pc_o;
    else if (halt_i | stall_i)  fetch_pc_d = fetch_pc_q;
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ex_valid_i && !(&branch_cnt_q)) branch_cnt_d  = branch_cnt_q + CNT_W'(1);
    if (flush_o && !(&mispred_cnt_q))   mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispred_cnt_q;

endmodule
